processador_nios2_qsys_0_oci_dct_monitor: RTL and testbench
===========================================================

Name: processador_nios2_qsys_0_oci_dct_monitor

Overview:
Parametrised successor to the OCI test-bench stub. It captures debug-trace (DCT) words and their count tag into an on-chip FIFO, and tracks the end-of-test handshake (test_ending, then test_has_ended) with a small state machine. It keeps sticky overflow and protocol-error status and accepted/dropped statistics, so a host or bench can drain the trace after the test ends. It sits beside the Nios II OCI block in the processador system.

Parameters:
DATA_W, 30, width of dct_buffer
CNT_W, 4, width of dct_count
DEPTH, 16, FIFO entries; power of two, at least 2
ADDR_W, 4, log2(DEPTH)
STAT_W, 16, width of the accepted and dropped counters

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
dct_buffer  in  DATA_W  trace word
dct_count  in  CNT_W  trace count tag
dct_valid  in  1  push request for {dct_count,dct_buffer}
test_ending  in  1  level; test is finishing
test_has_ended  in  1  level; test finished
rd_en  in  1  pop request
rd_data  out  CNT_W+DATA_W  popped entry, {count,buffer}
rd_valid  out  1  rd_data valid this cycle (one-cycle pulse)
fifo_level  out  ADDR_W+1  current occupancy, 0..DEPTH
empty  out  1  fifo_level==0
full  out  1  fifo_level==DEPTH
overflow  out  1  sticky; a push was dropped because the FIFO was full
proto_err  out  1  sticky; test_has_ended was seen in RUN
accepted_cnt  out  STAT_W  pushes written, saturating
dropped_cnt  out  STAT_W  pushes lost to full, saturating
state  out  2  0=RUN, 1=ENDING, 2=DRAIN, 3=ENDED
done  out  1  state==ENDED

Behaviour:
- Reset (async assert, sync release):
  - state=RUN; FIFO pointers, fifo_level, counters, rd_data, rd_valid, overflow and proto_err all 0.
  - empty=1, full=0, done=0.
  - Reset mid-operation discards the FIFO contents.
- Push window: a push is only attempted when state is RUN or ENDING.
  - In DRAIN and ENDED, dct_valid is ignored and no counter changes.
- Push acceptance: accepted if !full, or if full and a pop happens in the same cycle.
  - Accepted push: write at wr_ptr, wr_ptr+1 mod DEPTH, accepted_cnt+1 (saturates at all-ones).
- Push rejection (full with no pop): entry discarded, dropped_cnt+1 (saturating), overflow set to 1 and held until reset.
- Pop: happens when rd_en=1 and !empty.
  - rd_data is registered from rd_ptr; rd_ptr+1 mod DEPTH; rd_valid=1 on the next cycle.
  - Read latency is 1 cycle.
- Pop while empty: ignored; rd_valid=0 next cycle; rd_data holds its last value.
- Simultaneous push and pop:
  - fifo_level unchanged.
  - When empty, only the push takes effect: rd_valid stays 0, level becomes 1.
- fifo_level: +1 on push only, -1 on pop only. Pointers wrap modulo DEPTH with no bubble.
- State machine, evaluated every cycle:
  - RUN: test_has_ended -> DRAIN and proto_err=1 (test_has_ended takes priority over test_ending). Else test_ending -> ENDING.
  - ENDING: test_has_ended -> DRAIN. test_ending deasserting does not return to RUN.
  - DRAIN: when empty and no pop is in progress this cycle -> ENDED.
    - If already empty on entry, ENDED follows one cycle later.
    - A push in the same cycle as the transition into DRAIN is still accepted, because push eligibility uses the current state.
  - ENDED: terminal until reset. Pops remain legal but the FIFO is empty.
- Statistics and status flags never clear except on reset.

Test Plan:
- Reset, then push 5 words 0x1..0x5 with count tags 1..5, then pop 5 -> rd_data={1,0x1}..{5,0x5} in order, each with rd_valid one cycle after rd_en; fifo_level returns to 0; accepted_cnt=5.
- Push 20 words with no pops (DEPTH=16) -> full=1, fifo_level=16, accepted_cnt=16, dropped_cnt=4, overflow=1; draining returns the first 16 words in order.
- With the FIFO full, assert dct_valid and rd_en together for 1 cycle -> level stays 16, dropped_cnt unchanged, the new word is read out last.
- Push 3 words, assert test_ending, push 2 more, assert test_has_ended -> state goes 0->1->2; later dct_valid is ignored; after popping 5 entries state=3 and done=1; proto_err=0.
- From RUN, assert test_has_ended with an empty FIFO -> state=2, proto_err=1, state=3 on the following cycle.
- Assert reset_n=0 asynchronously mid-stream with 7 entries queued -> all outputs return to reset values immediately; empty=1, state=0.

Source files
------------

// File: rtl/processador_nios2_qsys_0_oci_dct_monitor.sv
// Debug-trace (DCT) capture FIFO with end-of-test handshake tracking,
// sticky overflow/protocol status and saturating accept/drop statistics.
module processador_nios2_qsys_0_oci_dct_monitor #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned STAT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    input  logic                    dct_valid,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    input  logic                    rd_en,
    output logic [CNT_W+DATA_W-1:0] rd_data,
    output logic                    rd_valid,
    output logic [ADDR_W:0]         fifo_level,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    proto_err,
    output logic [STAT_W-1:0]       accepted_cnt,
    output logic [STAT_W-1:0]       dropped_cnt,
    output logic [1:0]              state,
    output logic                    done
);

    localparam int unsigned ENT_W = CNT_W + DATA_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENDING = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_ENDED  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                perr_set;

    logic [ENT_W-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]    level_q;
    logic [LVL_W-1:0]    level_d;
    logic                empty_q;
    logic                full_q;
    logic [ENT_W-1:0]    rd_data_q;
    logic                rd_valid_q;
    logic                overflow_q;
    logic                proto_err_q;
    logic [STAT_W-1:0]   acc_q;
    logic [STAT_W-1:0]   drop_q;
    logic                done_q;

    logic                push_win;
    logic                push_req;
    logic                pop;
    logic                push_acc;
    logic                push_drop;

    // Push/pop qualification; a full FIFO still takes a push when a pop frees a slot
    always_comb begin
        push_win  = (state_q == ST_RUN) || (state_q == ST_ENDING);
        push_req  = dct_valid && push_win;
        pop       = rd_en && !empty_q;
        push_acc  = push_req && (!full_q || pop);
        push_drop = push_req && full_q && !pop;
        level_d   = level_q;
        case ({push_acc, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // End-of-test handshake: next state and protocol-error detection
    always_comb begin
        state_d  = state_q;
        perr_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (test_has_ended) begin
                    state_d  = ST_DRAIN;
                    perr_set = 1'b1;
                end else if (test_ending) begin
                    state_d = ST_ENDING;
                end
            end
            ST_ENDING: if (test_has_ended) state_d = ST_DRAIN;
            ST_DRAIN:  if (empty_q && !pop) state_d = ST_ENDED;
            ST_ENDED:  state_d = ST_ENDED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_ENDED);
        end
    end

    // Storage array is not reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= {dct_count, dct_buffer};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            acc_q       <= '0;
            drop_q      <= '0;
        end else begin
            level_q    <= level_d;
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == LVL_W'(DEPTH));
            rd_valid_q <= pop;
            if (push_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (acc_q != '1) acc_q <= acc_q + STAT_W'(1);
            end
            if (pop) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_W'(1);
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + STAT_W'(1);
            end
            if (perr_set) proto_err_q <= 1'b1;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign fifo_level   = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign overflow     = overflow_q;
    assign proto_err    = proto_err_q;
    assign accepted_cnt = acc_q;
    assign dropped_cnt  = drop_q;
    assign state        = state_q;
    assign done         = done_q;

endmodule

// File: tb/tb_processador_nios2_qsys_0_oci_dct_monitor.sv
// Directed + randomized bench for the DCT trace monitor, checked against a
// queue-based reference model of the FIFO, statistics and end-of-test handshake.
module tb_processador_nios2_qsys_0_oci_dct_monitor;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int STAT_W = 16;
    localparam int ENT_W  = CNT_W + DATA_W;
    localparam int SAT    = (1 << STAT_W) - 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [DATA_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]    dct_count;
    logic                dct_valid;
    logic                test_ending;
    logic                test_has_ended;
    logic                rd_en;
    logic [ENT_W-1:0]    rd_data;
    logic                rd_valid;
    logic [ADDR_W:0]     fifo_level;
    logic                empty;
    logic                full;
    logic                overflow;
    logic                proto_err;
    logic [STAT_W-1:0]   accepted_cnt;
    logic [STAT_W-1:0]   dropped_cnt;
    logic [1:0]          state;
    logic                done;

    processador_nios2_qsys_0_oci_dct_monitor #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
        .empty(empty), .full(full), .overflow(overflow), .proto_err(proto_err),
        .accepted_cnt(accepted_cnt), .dropped_cnt(dropped_cnt),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [ENT_W-1:0] mq[$];
    logic [ENT_W-1:0] m_rd_data;
    logic             m_rd_valid;
    logic             m_ovf;
    logic             m_perr;
    int               m_acc;
    int               m_drop;
    int               m_st;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "rd_valid",  64'(rd_valid),     64'(m_rd_valid));
        chk(tag, "rd_data",   64'(rd_data),      64'(m_rd_data));
        chk(tag, "level",     64'(fifo_level),   64'(mq.size()));
        chk(tag, "empty",     64'(empty),        64'(mq.size() == 0));
        chk(tag, "full",      64'(full),         64'(mq.size() == DEPTH));
        chk(tag, "overflow",  64'(overflow),     64'(m_ovf));
        chk(tag, "proto_err", 64'(proto_err),    64'(m_perr));
        chk(tag, "accepted",  64'(accepted_cnt), 64'(m_acc));
        chk(tag, "dropped",   64'(dropped_cnt),  64'(m_drop));
        chk(tag, "state",     64'(state),        64'(m_st));
        chk(tag, "done",      64'(done),         64'(m_st == 3));
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_perr     = 1'b0;
        m_acc      = 0;
        m_drop     = 0;
        m_st       = 0;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later
    task automatic step(input logic v, input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] b,
                        input logic te, input logic the, input logic rd, input string tag);
        int  pre;
        bit  do_pop;
        @(negedge clk);
        dct_valid = v; dct_count = c; dct_buffer = b;
        test_ending = te; test_has_ended = the; rd_en = rd;
        @(posedge clk);
        pre    = mq.size();
        do_pop = rd && (pre > 0);
        m_rd_valid = do_pop;
        if (do_pop) m_rd_data = mq.pop_front();
        if (v && (m_st == 0 || m_st == 1)) begin
            if (pre < DEPTH || do_pop) begin
                mq.push_back({c, b});
                if (m_acc < SAT) m_acc++;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < SAT) m_drop++;
            end
        end
        case (m_st)
            0: if (the) begin m_st = 2; m_perr = 1'b1; end else if (te) m_st = 1;
            1: if (the) m_st = 2;
            2: if (pre == 0 && !do_pop) m_st = 3;
            default: m_st = 3;
        endcase
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        dct_valid = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_en = 1'b0;
        model_reset();
        async_reset("reset");

        // Five pushes then five pops, in order, 1-cycle read latency
        for (int i = 1; i <= 5; i++) step(1'b1, CNT_W'(i), DATA_W'(i), 1'b0, 1'b0, 1'b0, "push5");
        for (int i = 1; i <= 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "pop5");
        chk("pop5", "last_entry", 64'(rd_data), 64'({4'd5, 30'd5}));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "pop_empty");

        // Overfill: 20 pushes into 16 entries, then full push+pop, then drain
        async_reset("reset2");
        for (int i = 0; i < 20; i++) step(1'b1, CNT_W'(i), DATA_W'(32'h100 + i), 1'b0, 1'b0, 1'b0, "overfill");
        chk("overfill", "dropped4", 64'(dropped_cnt), 64'd4);
        step(1'b1, 4'hA, DATA_W'(32'h2BAD), 1'b0, 1'b0, 1'b1, "full_push_pop");
        for (int i = 0; i < 17; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "drain16");
        chk("drain16", "last_new_word", 64'(rd_data), 64'({4'hA, DATA_W'(32'h2BAD)}));

        // Orderly end-of-test handshake
        async_reset("reset3");
        for (int i = 0; i < 3; i++) step(1'b1, CNT_W'(i), DATA_W'(32'h300 + i), 1'b0, 1'b0, 1'b0, "pre_end");
        step(1'b1, 4'd3, DATA_W'(32'h303), 1'b1, 1'b0, 1'b0, "ending");
        step(1'b1, 4'd4, DATA_W'(32'h304), 1'b0, 1'b0, 1'b0, "ending_hold");
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "has_ended");
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF, DATA_W'(32'hDEAD), 1'b0, 1'b0, 1'b1, "drain_ignore");
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "to_ended");
        chk("to_ended", "state3", 64'(state), 64'd3);
        chk("to_ended", "perr0", 64'(proto_err), 64'd0);

        // Protocol error: test_has_ended straight out of RUN with empty FIFO
        async_reset("reset4");
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "perr");
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "perr_ended");

        // Async reset with seven entries queued
        async_reset("reset5");
        for (int i = 0; i < 7; i++) step(1'b1, CNT_W'(i), DATA_W'(32'h700 + i), 1'b0, 1'b0, 1'b0, "fill7");
        async_reset("reset_mid");
        chk("reset_mid", "empty1", 64'(empty), 64'd1);

        // Randomized traffic, handshake enabled late in the run
        for (int i = 0; i < 400; i++) begin
            logic te_r, the_r;
            te_r  = (i > 200) && ($urandom_range(0, 15) == 0);
            the_r = (i > 300) && ($urandom_range(0, 15) == 0);
            step(1'($urandom_range(0, 9) < 6), CNT_W'($urandom), DATA_W'($urandom),
                 te_r, the_r, 1'($urandom_range(0, 9) < 4), "random");
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, "random_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
